// File: rtl/dpi_transmitter.sv
// DPI (parallel RGB) video timing generator with a two-stage output pipeline
// that absorbs the one-cycle read latency of the pixel source.
module dpi_transmitter #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit HSYNC_POL = 1'b1,
   parameter bit VSYNC_POL = 1'b1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        EN,
   input  logic [7:0]  PIX_RED,
   input  logic [7:0]  PIX_GREEN,
   input  logic [7:0]  PIX_BLUE,
   output logic [10:0] REQ_ADDR_H,
   output logic [9:0]  REQ_ADDR_V,
   output logic        REQ_VALID,
   output logic [7:0]  RED,
   output logic [7:0]  GREEN,
   output logic [7:0]  BLUE,
   output logic        HSYNC,
   output logic        VSYNC,
   output logic        DE,
   output logic        FRAME_START
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
   localparam logic [10:0] H_SS   = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] H_SE   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0]  V_SS   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;

   state_t      state, nxt_state;
   logic [10:0] cnt_h, nxt_h;
   logic [9:0]  cnt_v, nxt_v;
   logic        frame_end, nxt_active;
   logic        run, hs_c, vs_c, fs_c;
   logic        de_p, hs_p, vs_p, fs_p;

   // Next-state and counter advance; STOP keeps scanning so the frame completes unchanged.
   always_comb begin
      nxt_state = state;
      nxt_h     = cnt_h;
      nxt_v     = cnt_v;
      frame_end = (cnt_h == H_LAST) && (cnt_v == V_LAST);
      case (state)
         IDLE: begin
            nxt_h = 11'd0;
            nxt_v = 10'd0;
            if (EN) nxt_state = RUN;
            else    nxt_state = IDLE;
         end
         RUN, STOP: begin
            if (cnt_h == H_LAST) begin
               nxt_h = 11'd0;
               if (cnt_v == V_LAST) nxt_v = 10'd0;
               else                 nxt_v = cnt_v + 10'd1;
            end else begin
               nxt_h = cnt_h + 11'd1;
            end
            if (EN)             nxt_state = RUN;
            else if (frame_end) nxt_state = IDLE;
            else                nxt_state = STOP;
         end
         default: begin
            nxt_state = IDLE;
            nxt_h     = 11'd0;
            nxt_v     = 10'd0;
         end
      endcase
      nxt_active = (nxt_state != IDLE) && (nxt_h < H_ACT) && (nxt_v < V_ACT);
   end

   // Timing decodes for the position currently on the counters.
   always_comb begin
      run  = (state != IDLE);
      hs_c = run && (cnt_h >= H_SS) && (cnt_h < H_SE);
      vs_c = run && (cnt_v >= V_SS) && (cnt_v < V_SE);
      fs_c = REQ_VALID && (cnt_h == 11'd0) && (cnt_v == 10'd0);
   end

   // State, counters and the registered pixel request.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state      <= IDLE;
         cnt_h      <= 11'd0;
         cnt_v      <= 10'd0;
         REQ_VALID  <= 1'b0;
         REQ_ADDR_H <= 11'd0;
         REQ_ADDR_V <= 10'd0;
      end else begin
         state      <= nxt_state;
         cnt_h      <= nxt_h;
         cnt_v      <= nxt_v;
         REQ_VALID  <= nxt_active;
         REQ_ADDR_H <= nxt_active ? nxt_h : 11'd0;
         REQ_ADDR_V <= nxt_active ? nxt_v : 10'd0;
      end
   end

   // Two-stage delay: decodes wait one cycle for the pixel source, then join its data.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         de_p        <= 1'b0;
         hs_p        <= 1'b0;
         vs_p        <= 1'b0;
         fs_p        <= 1'b0;
         DE          <= 1'b0;
         RED         <= 8'd0;
         GREEN       <= 8'd0;
         BLUE        <= 8'd0;
         HSYNC       <= ~HSYNC_POL;
         VSYNC       <= ~VSYNC_POL;
         FRAME_START <= 1'b0;
      end else begin
         de_p        <= REQ_VALID;
         hs_p        <= hs_c;
         vs_p        <= vs_c;
         fs_p        <= fs_c;
         DE          <= de_p;
         RED         <= de_p ? PIX_RED   : 8'd0;
         GREEN       <= de_p ? PIX_GREEN : 8'd0;
         BLUE        <= de_p ? PIX_BLUE  : 8'd0;
         HSYNC       <= hs_p ? HSYNC_POL : ~HSYNC_POL;
         VSYNC       <= vs_p ? VSYNC_POL : ~VSYNC_POL;
         FRAME_START <= fs_p;
      end
   end

endmodule

// File: tb/tb_dpi_transmitter.sv
// Bench for dpi_transmitter on an 8x5 timing: phase table of EN patterns plus a
// per-cycle scoreboard of request and pipelined output values.
module tb_dpi_transmitter;

   localparam logic [27:0] POL_MASK = 28'h600_0000;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        EN = 1'b0;
   logic [7:0]  pix_r = 8'hFF, pix_g = 8'hFF, pix_b = 8'hFF;

   logic [10:0] ah1, ah2;
   logic [9:0]  av1, av2;
   logic        rv1, rv2, hs1, hs2, vs1, vs2, de1, de2, fs1, fs2;
   logic [7:0]  r1, g1, b1, r2, g2, b2;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic en;
      int   cycles;
      int   exp_de;
      int   exp_fs;
   } phase_t;

   phase_t phases[12];

   logic        m_run;
   int          m_h, m_v;
   logic        prev_valid;
   int          prev_h, prev_v;
   logic [27:0] sb[$];
   int          de_cnt, fs_cnt;

   dpi_transmitter #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
   ) u_dut (
      .CLK(CLK), .RESET(RESET), .EN(EN),
      .PIX_RED(pix_r), .PIX_GREEN(pix_g), .PIX_BLUE(pix_b),
      .REQ_ADDR_H(ah1), .REQ_ADDR_V(av1), .REQ_VALID(rv1),
      .RED(r1), .GREEN(g1), .BLUE(b1),
      .HSYNC(hs1), .VSYNC(vs1), .DE(de1), .FRAME_START(fs1)
   );

   dpi_transmitter #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
   ) u_dut_npol (
      .CLK(CLK), .RESET(RESET), .EN(EN),
      .PIX_RED(pix_r), .PIX_GREEN(pix_g), .PIX_BLUE(pix_b),
      .REQ_ADDR_H(ah2), .REQ_ADDR_V(av2), .REQ_VALID(rv2),
      .RED(r2), .GREEN(g2), .BLUE(b2),
      .HSYNC(hs2), .VSYNC(vs2), .DE(de2), .FRAME_START(fs2)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected output record {fs, vs, hs, de, r, g, b} for a scan position.
   function automatic logic [27:0] exp_rec(input logic run, input int h, input int v);
      logic       de, hs, vs, fs;
      logic [7:0] hb, vb;
      hb = 8'(h);
      vb = 8'(v);
      de = run && (h < 4) && (v < 2);
      hs = run && (h >= 5) && (h < 7);
      vs = run && (v == 3);
      fs = run && (h == 0) && (v == 0);
      return {fs, vs, hs, de,
              de ? 8'h10 + hb : 8'h00,
              de ? 8'h20 + hb : 8'h00,
              de ? 8'h30 + vb : 8'h00};
   endfunction

   task automatic model_reset();
      m_run      = 1'b0;
      m_h        = 0;
      m_v        = 0;
      prev_valid = 1'b0;
      prev_h     = 0;
      prev_v     = 0;
      sb.delete();
      sb.push_back(28'h0);
      sb.push_back(28'h0);
   endtask

   task automatic step();
      logic        en_prev, last, valid;
      logic [27:0] e;
      logic [21:0] req_exp;
      en_prev = EN;
      @(posedge CLK);
      #1;
      if (!m_run) begin
         if (en_prev) begin
            m_run = 1'b1;
            m_h   = 0;
            m_v   = 0;
         end
      end else begin
         last = (m_h == 7) && (m_v == 4);
         if (m_h == 7) begin
            m_h = 0;
            m_v = (m_v == 4) ? 0 : m_v + 1;
         end else begin
            m_h = m_h + 1;
         end
         m_run = en_prev || !last;
      end
      valid   = m_run && (m_h < 4) && (m_v < 2);
      req_exp = {valid, valid ? 11'(m_h) : 11'd0, valid ? 10'(m_v) : 10'd0};
      check("req", {10'd0, rv1, ah1, av1}, {10'd0, req_exp});
      check("req_npol", {10'd0, rv2, ah2, av2}, {10'd0, req_exp});
      // Source answers the previous cycle's request; blanking reads return FF.
      pix_r = prev_valid ? 8'h10 + 8'(prev_h) : 8'hFF;
      pix_g = prev_valid ? 8'h20 + 8'(prev_h) : 8'hFF;
      pix_b = prev_valid ? 8'h30 + 8'(prev_v) : 8'hFF;
      prev_valid = valid;
      prev_h     = m_h;
      prev_v     = m_v;
      sb.push_back(exp_rec(m_run, m_h, m_v));
      e = sb.pop_front();
      check("out", {4'd0, fs1, vs1, hs1, de1, r1, g1, b1}, {4'd0, e});
      check("out_npol", {4'd0, fs2, vs2, hs2, de2, r2, g2, b2}, {4'd0, e ^ POL_MASK});
      if (de1) de_cnt++;
      if (fs1) fs_cnt++;
   endtask

   task automatic run_phase(input int idx);
      EN     = phases[idx].en;
      de_cnt = 0;
      fs_cnt = 0;
      for (int c = 0; c < phases[idx].cycles; c++) step();
      check($sformatf("de_count[%0d]", idx), de_cnt, phases[idx].exp_de);
      check($sformatf("fs_count[%0d]", idx), fs_cnt, phases[idx].exp_fs);
   endtask

   task automatic check_blank(input string name);
      check({name, "_out"}, {4'd0, fs1, vs1, hs1, de1, r1, g1, b1}, 32'd0);
      check({name, "_out_npol"}, {4'd0, fs2, vs2, hs2, de2, r2, g2, b2}, {4'd0, POL_MASK});
      check({name, "_req"}, {10'd0, rv1, ah1, av1}, 32'd0);
   endtask

   initial begin
      phases[0]  = '{1'b0,  5, 0, 0};  // idle stays blank
      phases[1]  = '{1'b1, 40, 8, 1};  // first frame
      phases[2]  = '{1'b1, 40, 8, 1};  // back-to-back frame
      phases[3]  = '{1'b1,  2, 0, 0};  // pixels 0,1 of line 0
      phases[4]  = '{1'b0, 38, 8, 1};  // EN dropped at pixel 2: frame completes
      phases[5]  = '{1'b0,  6, 0, 0};  // idle after frame end
      phases[6]  = '{1'b1, 20, 8, 1};  // restart
      phases[7]  = '{1'b0, 10, 0, 0};  // stop mid-frame
      phases[8]  = '{1'b1, 10, 0, 0};  // re-raise during stop
      phases[9]  = '{1'b1, 10, 4, 1};  // next frame with no gap
      phases[10] = '{1'b1,  3, 3, 0};  // into line 1
      phases[11] = '{1'b1,  6, 4, 1};  // restart after mid-line reset

      repeat (3) @(posedge CLK);
      #1;
      check_blank("reset");
      RESET = 1'b0;
      model_reset();

      for (int i = 0; i < 11; i++) run_phase(i);

      #3;
      RESET = 1'b1;
      #1;
      check_blank("async_reset");
      @(posedge CLK);
      #1;
      check_blank("held_reset");
      RESET = 1'b0;
      model_reset();

      run_phase(11);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dpi_transmitter.md
DPI_TRANSMITTER -- requirements
Module: dpi_transmitter

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch clocks
- H_SYNC, 96, HSYNC width in clocks
- H_BP, 48, horizontal back porch clocks
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch lines
- V_SYNC, 2, VSYNC width in lines
- V_BP, 33, vertical back porch lines
- HSYNC_POL, 1, asserted level of HSYNC
- VSYNC_POL, 1, asserted level of VSYNC
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- CLK, in, 1, pixel clock; one clock, all logic on its rising edge
- RESET, in, 1, asynchronous, active-high reset
- EN, in, 1, run request
- PIX_RED / PIX_GREEN / PIX_BLUE, in, 8 each, pixel data from source, one-cycle read latency
- REQ_ADDR_H, out, 11, requested pixel column
- REQ_ADDR_V, out, 10, requested pixel row
- REQ_VALID, out, 1, request strobe, high for active-region addresses only
- RED / GREEN / BLUE, out, 8 each, DPI pixel data
- HSYNC / VSYNC / DE, out, 1 each, DPI timing
- FRAME_START, out, 1, one-clock pulse with the first active pixel of each frame
REQ-003 Parameter limits SHALL be: H total (H_ACTIVE+H_FP+H_SYNC+H_BP) <= 2048; V total <= 1024; every parameter >= 1.

Function
REQ-004 Line order SHALL be active, front porch, sync, back porch (default 800 clocks); frame order SHALL be the same in lines (default 525 lines).
REQ-005 Counters SHALL be cnt_h (11 bit) and cnt_v (10 bit). cnt_h wraps from H total-1 to 0. cnt_v increments on each cnt_h wrap and wraps from V total-1 to 0.
REQ-006 Active region SHALL be cnt_h < H_ACTIVE and cnt_v < V_ACTIVE.
REQ-007 HSYNC SHALL be asserted for H_ACTIVE+H_FP <= cnt_h < H_ACTIVE+H_FP+H_SYNC. VSYNC SHALL be asserted for V_ACTIVE+V_FP <= cnt_v < V_ACTIVE+V_FP+V_SYNC, over whole lines.
REQ-008 FSM states SHALL be IDLE, RUN and STOP:
- IDLE to RUN when EN=1, starting at cnt_h=0, cnt_v=0.
- RUN to STOP when EN=0.
- STOP to RUN when EN=1 before frame end.
- STOP to IDLE at frame end (cnt_h=H total-1, cnt_v=V total-1).
- In STOP the current frame SHALL complete unchanged.
REQ-009 In IDLE, counters SHALL hold 0, REQ_VALID=0, and outputs SHALL be at blank values (RGB=0, DE=0, syncs deasserted).
REQ-010 REQ_ADDR_H/V SHALL equal cnt_h/cnt_v when REQ_VALID=1 and SHALL be 0 otherwise. REQ_VALID SHALL be 1 exactly in the active region while in RUN/STOP.
REQ-011 Pipeline timing:
- Counters show (h,v) in cycle t.
- PIX_* for (h,v) SHALL be sampled at the edge ending cycle t+1.
- RED/GREEN/BLUE, DE, HSYNC, VSYNC and FRAME_START for (h,v) SHALL all appear together in cycle t+2.
- Sync and DE decodes SHALL be delayed two registers to match.
REQ-012 RGB outputs SHALL be 0 whenever DE=0, regardless of PIX_*.
REQ-013 FRAME_START SHALL be high for exactly the single output cycle of pixel (0,0).
REQ-014 All outputs SHALL be registered; no combinational input-to-output path.
REQ-015 On IDLE entry, the last in-flight pixels SHALL drain through the 2-stage pipeline normally.

Reset
REQ-016 While RESET=1: state=IDLE, counters=0, pipeline registers cleared, RGB=0, DE=0, REQ_VALID=0, REQ_ADDR=0, FRAME_START=0, HSYNC=~HSYNC_POL, VSYNC=~VSYNC_POL.
REQ-017 RESET asserted mid-frame SHALL force the REQ-016 values immediately (asynchronous). After release, a new frame SHALL start from (0,0) only once EN=1 is sampled.

Verification
Small test parameters: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1 (8 clocks); V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1 (5 lines).
REQ-018 Reset then EN=1 -> REQ_VALID high for cnt_h 0..3 on lines 0..1; first DE 2 clocks after first REQ_VALID; FRAME_START coincides with the first DE.
REQ-019 PIX = 8'h10+column on each channel -> RGB out 10,11,12,13 on DE cycles; 0 in blanking even with PIX=FF.
REQ-020 HSYNC high at output clocks 5..6 of each 8-clock line (pipeline-adjusted); VSYNC high for all 8 clocks of line 3 only; HSYNC_POL=0 -> HSYNC inverted.
REQ-021 EN dropped at line 0, pixel 2 -> frame completes all 40 clocks, then IDLE with blank outputs; EN re-raised during STOP -> next frame follows back-to-back with no gap.
REQ-022 RESET pulse mid-line 1 -> outputs blank in the same cycle; with EN held 1 after release, restart at (0,0) with FRAME_START.
REQ-023 Default parameters -> 800 clocks between HSYNC rising edges, 420000 clocks between FRAME_START pulses, 307200 DE cycles per frame.
